// File: rtl/rv32_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_lsu_pkg
// Description : Shared definitions for the RV32 load/store path.
//               funct3 access-size codes, FSM state encoding reused by other
//               pipeline stages, and the request legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_lsu_pkg;

  // RV32I load/store funct3 codes
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // A request is legal when funct3 names an access of the right kind and the
  // byte offset is naturally aligned to the access size.
  function automatic logic req_legal(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] off);
    logic f3_ok;
    logic align_ok;
    if (we) begin
      f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      f3_ok = (funct3 == F3_B)  || (funct3 == F3_H)  || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    case (funct3[1:0])
      2'd1:    align_ok = ~off[0];
      2'd2:    align_ok = (off == 2'd0);
      default: align_ok = 1'b1;
    endcase
    return f3_ok & align_ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_lsu_if
// Description : Bundle of the LSU request, response and BRAM signals.
//               slave  : the LSU side (accepts requests, drives the BRAM).
//               master : the core/BRAM side (issues requests, returns data).
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_lsu_if #(
  parameter int XLEN = 32
);
  // request channel
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [2:0]      req_funct3_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic [4:0]      req_rd_i;
  // response channel
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [XLEN-1:0] rsp_rdata_o;
  logic [4:0]      rsp_rd_o;
  logic            rsp_err_o;
  // data BRAM port
  logic [XLEN-1:0] mem_addr_o;
  logic [3:0]      mem_we_o;
  logic [XLEN-1:0] mem_wd_o;
  logic [XLEN-1:0] mem_rd_i;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
           req_rd_i, rsp_ready_i, mem_rd_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_rd_o, rsp_err_o,
           mem_addr_o, mem_we_o, mem_wd_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
           req_rd_i, rsp_ready_i, mem_rd_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_rd_o, rsp_err_o,
           mem_addr_o, mem_we_o, mem_wd_o
  );

endinterface
`default_nettype wire

// File: rtl/rv32_load_align.sv
`default_nettype none
// ============================================================================
// Module      : rv32_load_align
// Description : Combinational load extraction. Shifts the BRAM word down to
//               the addressed byte lane, then sign- or zero-extends it.
// Ports       : rd_word  - raw BRAM read word
//               byte_off - address bits [1:0]
//               funct3   - load type (LB/LH/LW/LBU/LHU)
//               data     - extended result; 0 for a non-load funct3
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_load_align
  import rv32_lsu_pkg::*;
(
  input  wire logic [31:0] rd_word,
  input  wire logic [1:0]  byte_off,
  input  wire logic [2:0]  funct3,
  output logic      [31:0] data
);

  logic [31:0] w_shifted;

  assign w_shifted = rd_word >> {byte_off, 3'b000};

  always_comb begin
    data = 32'd0;
    case (funct3)
      F3_B:    data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      F3_H:    data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    data = w_shifted;
      F3_BU:   data = {24'd0, w_shifted[7:0]};
      F3_HU:   data = {16'd0, w_shifted[15:0]};
      default: data = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32_lsu.sv
`default_nettype none
// ============================================================================
// Module      : rv32_lsu
// Description : Load/store unit between the ALU result and the data BRAM.
//               One transaction at a time: IDLE -> ISSUE -> (WAIT) -> RESP,
//               or IDLE -> RESP directly for an illegal request.
// Ports       : clk_i, rst_i - clock, synchronous active-high reset
//               bus (slave)  - request, response and BRAM signals
// Parameters  : XLEN (32 only), MEM_LAT (BRAM read latency, 1..4)
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_lsu
  import rv32_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  rv32_lsu_if.slave bus
);

  lsu_state_e      r_state;
  lsu_state_e      w_state_next;

  logic [1:0]      r_off;
  logic [XLEN-1:0] r_wdata;
  logic [2:0]      r_funct3;
  logic            r_we;
  logic [4:0]      r_rd;
  logic [1:0]      r_cnt;
  logic [XLEN-1:0] r_rsp_rdata;
  logic            r_rsp_err;
  logic [XLEN-1:0] r_mem_addr;

  logic            w_req_ready;
  logic            w_accept;
  logic            w_legal;
  logic [3:0]      w_we_mask;
  logic [XLEN-1:0] w_wd;
  logic [XLEN-1:0] w_ld_data;

  assign w_req_ready = (r_state == ST_IDLE) && !rst_i;
  assign w_accept    = bus.req_valid_i && w_req_ready;
  assign w_legal     = req_legal(bus.req_we_i, bus.req_funct3_i, bus.req_addr_i[1:0]);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_legal ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: w_state_next = r_we ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Store lane steering; only legal store sizes ever reach ISSUE.
  always_comb begin
    w_we_mask = 4'b1111;
    w_wd      = r_wdata;
    case (r_funct3[1:0])
      2'd0: begin
        w_we_mask = 4'b0001 << r_off;
        w_wd      = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_we_mask = r_off[1] ? 4'b1100 : 4'b0011;
        w_wd      = {2{r_wdata[15:0]}};
      end
      default: begin
        w_we_mask = 4'b1111;
        w_wd      = r_wdata;
      end
    endcase
  end

  rv32_load_align u_load_align (
    .rd_word  (bus.mem_rd_i),
    .byte_off (r_off),
    .funct3   (r_funct3),
    .data     (w_ld_data)
  );

  // Transaction datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_off       <= 2'd0;
      r_wdata     <= '0;
      r_funct3    <= 3'd0;
      r_we        <= 1'b0;
      r_rd        <= 5'd0;
      r_cnt       <= 2'd0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      if (w_accept) begin
        r_off       <= bus.req_addr_i[1:0];
        r_wdata     <= bus.req_wdata_i;
        r_funct3    <= bus.req_funct3_i;
        r_we        <= bus.req_we_i;
        r_rd        <= bus.req_rd_i;
        r_rsp_rdata <= '0;
        r_rsp_err   <= !w_legal;
        // An illegal request performs no access, so the BRAM address keeps
        // its previous value.
        if (w_legal) begin
          r_mem_addr <= {bus.req_addr_i[XLEN-1:2], 2'b00};
        end
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= 2'(MEM_LAT - 1);
      end
      if (r_state == ST_WAIT) begin
        if (r_cnt == 2'd0) begin
          r_rsp_rdata <= w_ld_data;
        end else begin
          r_cnt <= r_cnt - 2'd1;
        end
      end
    end
  end

  assign bus.req_ready_o = w_req_ready;
  assign bus.rsp_valid_o = (r_state == ST_RESP);
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_rd_o    = r_rd;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.mem_addr_o  = r_mem_addr;
  // Write enables are gated by reset directly so a reset landing on the
  // ISSUE cycle can never commit a write.
  assign bus.mem_we_o    = ((r_state == ST_ISSUE) && r_we && !rst_i) ? w_we_mask : 4'b0000;
  assign bus.mem_wd_o    = ((r_state == ST_ISSUE) && r_we) ? w_wd : '0;

endmodule
`default_nettype wire

// File: tb/tb_rv32_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_lsu
// Description : Randomized scoreboard bench for rv32_lsu with a byte-level
//               memory reference model and a latency-accurate BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_lsu;

  localparam int MEM_LAT = 2;
  localparam int NWORDS  = 64;
  localparam int NRAND   = 300;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
    int          lat;
    int          acc;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wd;
    int          cyc;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic bram_load;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  rsp_exp_t    rsp_q[$];
  wr_exp_t     wr_q[$];
  logic [31:0] ref_mem [NWORDS];
  logic [31:0] bram    [NWORDS];
  logic [31:0] rd_pipe [MEM_LAT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv32_lsu_if #(.XLEN(32)) bus ();

  rv32_lsu #(.XLEN(32), .MEM_LAT(MEM_LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] seed_word(int i);
    logic [31:0] v;
    if (i == 0 || i == 4) return 32'h80FF0000;
    v = 32'(i) * 32'h9E3779B1;
    return v ^ 32'h5A5A1234;
  endfunction

  // BRAM model: byte-lane writes, read data MEM_LAT cycles after the address edge
  always @(posedge clk) begin
    if (bram_load) begin
      for (int i = 0; i < NWORDS; i++) bram[i] <= seed_word(i);
    end else begin
      for (int l = 0; l < 4; l++)
        if (bus.mem_we_o[l]) bram[bus.mem_addr_o[7:2]][8*l +: 8] <= bus.mem_wd_o[8*l +: 8];
    end
    rd_pipe[0] <= bram[bus.mem_addr_o[7:2]];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rd_i = rd_pipe[MEM_LAT-1];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic bit is_legal(bit we, logic [2:0] f3, logic [31:0] addr);
    bit ok;
    if (we) ok = (f3 <= 3'd2);
    else    ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return ok && ((int'(addr[1:0]) % acc_size(f3)) == 0);
  endfunction

  function automatic logic [31:0] load_model(logic [31:0] word, int off, logic [2:0] f3);
    longint w;
    longint v;
    int     size;
    size = acc_size(f3);
    w = longint'(word);
    v = (w >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
    if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
      v = v - (longint'(1) << (8 * size));
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic accept_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd,
                            output bit ok, output int acc);
    int guard;
    guard = 0;
    ok = 1'b1;
    @(negedge clk);
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wdata;
    bus.req_rd_i     = rd;
    bus.req_valid_i  = 1'b1;
    while (!bus.req_ready_o) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        chk("req_accept_timeout", 32'(guard), 32'd0);
        bus.req_valid_i = 1'b0;
        ok = 1'b0;
        acc = cyc;
        return;
      end
    end
    acc = cyc;
  endtask

  task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd);
    bit       ok;
    int       acc;
    int       off;
    int       idx;
    int       size;
    bit       legal;
    rsp_exp_t e;
    wr_exp_t  w;
    accept_req(we, f3, addr, wdata, rd, ok, acc);
    if (!ok) return;
    legal  = is_legal(we, f3, addr);
    off    = int'(addr[1:0]);
    idx    = int'(addr[7:2]);
    size   = acc_size(f3);
    e.rd   = rd;
    e.acc  = acc;
    e.err  = !legal;
    e.rdata = 32'd0;
    if (!legal) begin
      e.lat = 1;
    end else if (we) begin
      e.lat  = 2;
      w.addr = {addr[31:2], 2'b00};
      w.we   = 4'b0000;
      w.cyc  = acc + 1;
      for (int i = 0; i < size; i++) begin
        ref_mem[idx][8*(off+i) +: 8] = wdata[8*i +: 8];
        w.we[off+i] = 1'b1;
      end
      for (int l = 0; l < 4; l++) w.wd[8*l +: 8] = wdata[8*(l % size) +: 8];
      wr_q.push_back(w);
    end else begin
      e.lat   = 2 + MEM_LAT;
      e.rdata = load_model(ref_mem[idx], off, f3);
    end
    rsp_q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    if (legal) begin
      @(negedge clk);
      chk("issue_mem_addr", bus.mem_addr_o, {addr[31:2], 2'b00});
    end
  endtask

  // ---------------- response monitor ----------------
  bit       in_resp = 1'b0;
  bit       hs_prev = 1'b0;
  rsp_exp_t cur;

  always @(negedge clk) begin
    if (!rst && hs_prev) begin
      chk("idle_after_hs_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("idle_after_hs_ready", 32'(bus.req_ready_o), 32'd1);
    end
    hs_prev = 1'b0;
    bus.rsp_ready_i = ($urandom_range(0, 2) != 0);
    if (rst) begin
      in_resp = 1'b0;
    end else if (bus.rsp_valid_o) begin
      chk("ready_low_in_resp", 32'(bus.req_ready_o), 32'd0);
      if (!in_resp) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(bus.rsp_valid_o), 32'd0);
          cur.rdata = bus.rsp_rdata_o;
          cur.rd    = bus.rsp_rd_o;
          cur.err   = bus.rsp_err_o;
        end else begin
          cur = rsp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata_o, cur.rdata);
          chk("rsp_rd", 32'(bus.rsp_rd_o), 32'(cur.rd));
          chk("rsp_err", 32'(bus.rsp_err_o), 32'(cur.err));
          chk("rsp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
        end
        in_resp = 1'b1;
      end else begin
        chk("held_rdata", bus.rsp_rdata_o, cur.rdata);
        chk("held_rd", 32'(bus.rsp_rd_o), 32'(cur.rd));
        chk("held_err", 32'(bus.rsp_err_o), 32'(cur.err));
      end
      if (bus.rsp_ready_i) begin
        in_resp = 1'b0;
        hs_prev = 1'b1;
      end
    end
  end

  // ---------------- write monitor ----------------
  always @(negedge clk) begin
    if (bus.mem_we_o !== 4'b0000) begin
      if (wr_q.size() == 0) begin
        chk("spurious_write", 32'(bus.mem_we_o), 32'd0);
      end else begin
        wr_exp_t w;
        w = wr_q.pop_front();
        chk("wr_addr", bus.mem_addr_o, w.addr);
        chk("wr_we", 32'(bus.mem_we_o), 32'(w.we));
        chk("wr_wd", bus.mem_wd_o, w.wd);
        chk("wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while ((rsp_q.size() != 0 || bus.rsp_valid_o) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", 32'(rsp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata_o, 32'd0);
    chk({tag, "_rsp_rd"}, 32'(bus.rsp_rd_o), 32'd0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err_o), 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr_o, 32'd0);
    chk({tag, "_mem_wd"}, bus.mem_wd_o, 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we_o), 32'd0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          acc;
    logic [31:0] r;
    logic [31:0] addr;
    logic [2:0]  f3;
    bit          we;

    rst = 1'b1;
    bram_load = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'd0;
    bus.req_addr_i   = 32'd0;
    bus.req_wdata_i  = 32'd0;
    bus.req_rd_i     = 5'd0;
    bus.rsp_ready_i  = 1'b1;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = seed_word(i);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    bram_load = 1'b0;

    // directed cases
    send(1'b0, 3'd0, 32'h0000_0013, 32'd0, 5'd1);        // LB  -> FFFFFF80
    send(1'b0, 3'd4, 32'h0000_0013, 32'd0, 5'd2);        // LBU -> 00000080
    send(1'b0, 3'd1, 32'h0000_0002, 32'd0, 5'd3);        // LH  -> FFFF80FF
    send(1'b1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, 5'd4); // SW
    send(1'b1, 3'd1, 32'h0000_0006, 32'h0000_1234, 5'd5);// SH upper half
    send(1'b0, 3'd2, 32'h0000_0002, 32'd0, 5'd6);        // LW misaligned
    send(1'b1, 3'd3, 32'h0000_0000, 32'hFFFF_FFFF, 5'd7);// store funct3=3
    send(1'b0, 3'd2, 32'h0000_0010, 32'd0, 5'd8);        // LW readback
    send(1'b0, 3'd5, 32'h0000_0006, 32'd0, 5'd9);        // LHU readback
    send(1'b0, 3'd6, 32'h0000_0000, 32'd0, 5'd10);       // illegal load funct3

    // randomized traffic
    for (int n = 0; n < NRAND; n++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (acc_size(f3) == 2) addr[0] = 1'b0;
        if (acc_size(f3) >= 4) addr[1:0] = 2'b00;
      end
      r = $urandom();
      send(we, f3, addr, r, 5'($urandom_range(0, 31)));
    end
    drain();

    // reset during a store's ISSUE cycle
    accept_req(1'b1, 3'd2, 32'h0000_0020, 32'hA5A5A5A5, 5'd11, ok, acc);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_issue_we", 32'(bus.mem_we_o), 32'd0);
    @(negedge clk);
    check_reset_outputs("rst_store");
    rst = 1'b0;
    #1 chk("rst_store_ready_back", 32'(bus.req_ready_o), 32'd1);
    chk("rst_store_no_write", bram[8], ref_mem[8]);

    // reset during a load's WAIT cycle
    accept_req(1'b0, 3'd2, 32'h0000_0024, 32'd0, 5'd12, ok, acc);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_we", 32'(bus.mem_we_o), 32'd0);
    @(negedge clk);
    check_reset_outputs("rst_load");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
    end

    // recovery after reset
    send(1'b0, 3'd2, 32'h0000_0010, 32'd0, 5'd13);
    send(1'b1, 3'd0, 32'h0000_0031, 32'h0000_00C3, 5'd14);
    send(1'b0, 3'd0, 32'h0000_0031, 32'd0, 5'd15);
    drain();
    repeat (4) @(negedge clk);
    chk("pending_writes", 32'(wr_q.size()), 32'd0);
    chk("pending_rsps", 32'(rsp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
